wdata_chan_subo: RTL

WDATA_CHAN_SUBO -- requirements
Module: wdata_chan_subo

---
 rtl/wdata_chan_subo.sv | 109 ++++++++++
 1 files changed

// File: rtl/wdata_chan_subo.sv
// Write-data channel subordinate: accepts a burst of write beats after a request,
// issues one memory write per beat and pulses finish_swd when the burst completes.
module wdata_chan_subo #(
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reqc_s_valid,
  input  logic [31:0]     reqc_s_addr,
  input  logic [LENW-1:0] reqc_s_len,
  input  logic            wvalid,
  output logic            wready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_be,
  output logic            finish_swd,
  output logic            wlast_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    FINISH = 2'b10,
    TRAP   = 2'b11
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [31:0]     addr_reg;
  logic [LENW-1:0] cnt_reg;
  logic            wlast_err_reg;
  logic            beat;
  logic            last_beat;

  assign beat      = wvalid && wready;
  assign last_beat = (cnt_reg == '0);

  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = TRAP;
    case (state_reg)
      IDLE:    state_next = reqc_s_valid ? DATA : IDLE;
      DATA:    state_next = (beat && last_beat) ? FINISH : DATA;
      FINISH:  state_next = IDLE;
      default: state_next = TRAP;
    endcase
  end

  always_comb begin
    wready     = 1'b0;
    finish_swd = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE:    busy = 1'b0;
      DATA:    wready = 1'b1;
      FINISH:  finish_swd = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // The beat count decides burst length; wlast only feeds the error flag.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      addr_reg      <= '0;
      cnt_reg       <= '0;
      wlast_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (reqc_s_valid) begin
            addr_reg      <= reqc_s_addr;
            cnt_reg       <= reqc_s_len;
            wlast_err_reg <= 1'b0;
          end
        end
        DATA: begin
          if (beat) begin
            addr_reg <= addr_reg + 32'd4;
            cnt_reg  <= cnt_reg - LENW'(1);
            if (wlast != last_beat) begin
              wlast_err_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = beat;
  assign mem_addr  = {addr_reg[31:2], 2'b00};
  assign mem_wdata = wdata;
  assign mem_be    = wstrb;
  assign wlast_err = wlast_err_reg;

endmodule
